// File: rtl/instr_loader_pkg.sv
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared types and opcode constants for the instruction loader
//                and the control-unit decode.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

  // Request kind carried on req_kind
  typedef enum logic [1:0] {
    KIND_RTYPE  = 2'b00,
    KIND_LOAD   = 2'b01,
    KIND_STORE  = 2'b10,
    KIND_BRANCH = 2'b11
  } kind_e;

  // RV32I major opcodes, shared with the decoder
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_field_encoder.sv
// ============================================================================
//  Module      : instr_field_encoder
//  Description : Combinational packing of a field-level request into a 32-bit
//                RV32I word. With INSTR_LOADER_CHECK_EN defined, immediates
//                that cannot be represented are flagged as illegal.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_encoder
  import instr_loader_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Pack fields by kind; fields a kind does not use are simply dropped
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (kind_e'(kind))
      KIND_RTYPE:  word = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
      KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], OPC_BRANCH};
    endcase
`ifdef INSTR_LOADER_CHECK_EN
    // LW/SW carry a 12-bit signed immediate: bit 12 must be a sign copy.
    // Branch offsets are halfword aligned: bit 0 must be clear.
    case (kind_e'(kind))
      KIND_LOAD, KIND_STORE: illegal = (imm[12] != imm[11]);
      KIND_BRANCH:           illegal = imm[0];
      default:               illegal = 1'b0;
    endcase
`endif
  end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module      : instr_loader
//  Description : Accepts instruction requests over valid/ready, encodes them
//                and writes them to consecutive instruction-memory words.
//                Optional macro: INSTR_LOADER_CHECK_EN (illegal-field check).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q;
  logic              last_q;
  logic              illegal_q;
  logic              full_q;
  logic              err_q;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  instr_field_encoder u_enc (
    .kind    (req_kind),
    .funct3  (req_funct3),
    .funct7  (req_funct7),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; an illegal request never touches memory so it cannot
  // fill the last word
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  if (req_valid) state_nx = ST_WRITE;
      ST_WRITE: begin
        if (last_q || (!illegal_q && (ptr_q == LAST_ADDR))) state_nx = ST_DONE;
        else                                                 state_nx = ST_LOAD;
      end
      ST_DONE:  state_nx = ST_IDLE;
    endcase
  end

  // Pointer, count, captured word and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= BASE;
      count_q   <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr_q   <= BASE;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (req_valid) begin
            word_q    <= enc_word;
            last_q    <= req_last;
            illegal_q <= enc_illegal;
          end
        end
        ST_WRITE: begin
          if (illegal_q) begin
            err_q <= 1'b1;
          end else begin
            count_q <= count_q + (ADDR_W+1)'(1);
            // The pointer parks on the last word instead of wrapping
            if (ptr_q == LAST_ADDR) begin
              if (!last_q) full_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == ST_LOAD);
  assign imem_we    = (state == ST_WRITE) && !illegal_q;
  assign imem_addr  = ptr_q;
  assign imem_wdata = word_q;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign full       = full_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

`default_nettype wire
